mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store unit sitting directly upstream of the word-only data memory in the MIPS datapath.
- Accepts one memory request at a time from the MEM pipeline stage and translates it into word-aligned LW/SW memory operations.
- Handles LB/LBU/LH/LHU by lane extraction and sign/zero extension.
- Handles SB/SH by a read-modify-write sequence.
- Detects misaligned and out-of-range addresses without touching memory.

Parameters:
MEM_WORDS, 1024, number of 32-bit words in the data memory; word index must be < MEM_WORDS.
OP_NOP, 6'h00, opcode driven on mem_op when no memory access is intended.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous reset, active low
req_valid  in  1  request present from pipeline
req_ready  out  1  unit idle, request accepted when req_valid && req_ready
req_op  in  6  MIPS opcode (LB 20, LH 21, LW 23, LBU 24, LHU 25, SB 28, SH 29, SW 2B, hex)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified for SB/SH
resp_valid  out  1  one-cycle pulse, access completed (load or store)
resp_rdata  out  32  extended load result, valid with resp_valid on loads; 0 for stores
exc_valid  out  1  one-cycle pulse, access faulted
exc_cause  out  2  1 = misaligned, 2 = out of range
exc_addr  out  32  faulting byte address
mem_op  out  6  registered opcode to data memory (LW/SW/OP_NOP)
mem_addr  out  32  registered word-aligned byte address to data memory
mem_wdata  out  32  registered full-word write value
mem_rdata  in  32  combinational read word from data memory at mem_addr

Behaviour:
- Reset (reset_n low at a posedge):
  - state = IDLE.
  - mem_op = OP_NOP; mem_addr, mem_wdata, resp_rdata, exc_addr = 0.
  - resp_valid, exc_valid, exc_cause = 0; req_ready = 1 after reset.
- req_ready = 1 only in IDLE.
- Request acceptance:
  - A request is accepted only when req_valid && req_ready; the unit latches op, addr and wdata.
  - Requests carrying an opcode outside the eight above are ignored: no latch, no response.
- Checks at accept, in priority order:
  - Misaligned: LH/LHU/SH with addr[0] = 1, or LW/SW with addr[1:0] != 0.
  - Out of range: addr[31:2] >= MEM_WORDS.
  - On a fault: next state FAULT, exc_valid pulses in the following cycle with cause and addr, mem_op stays OP_NOP, then IDLE.
- Byte lanes are big-endian. Byte offset 0 is bits [31:24], offset 3 is bits [7:0]; halfword offset 0 is [31:16], offset 2 is [15:0].
- States: IDLE, LOAD, RMW_READ, WRITE, RESP, FAULT.
- Load (accept at cycle N):
  - N+1 is the LOAD state: mem_op = LW, mem_addr = {addr[31:2],2'b00}.
  - At the end of N+1, mem_rdata is captured, lane-extracted and extended: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - N+2 is RESP: resp_valid = 1, resp_rdata valid.
  - The unit returns to IDLE at N+3, so its throughput is one request per 3 cycles.
- SW:
  - N+1 is WRITE: mem_op = SW, mem_wdata = wdata.
  - N+2 is RESP.
- SB/SH:
  - N+1 is RMW_READ: mem_op = OP_NOP, mem_addr set; mem_rdata is captured.
  - N+2 is WRITE: the captured word with only the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - N+3 is RESP.
- mem_op is SW for exactly one cycle per store, and never SW outside WRITE.
- Reset mid-operation:
  - Reset sampled in any state before WRITE aborts the access with no memory write.
  - Reset sampled during WRITE still commits that write, because memory samples mem_op at the same edge; the unit itself returns to IDLE.
  - No response pulse is produced for an aborted access.
- req_valid held during a busy period is simply not accepted. The pipeline must hold the request until it sees req_ready.

Decomposition:
- Shared package mips_mem_pkg:
  - Opcode constants LB/LH/LW/LBU/LHU/SB/SH/SW/OP_NOP.
  - exc_cause encodings.
  - State enum.
- Sub-module mem_lane_unit (purely combinational), containing:
  - Load extraction/extension from word, offset and opcode.
  - Store merge from old word, offset, opcode and wdata.
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Memory word 5 = 32'h80FF1234. LB at addr 0x14 -> resp_rdata 32'hFFFFFF80. LBU at 0x15 -> 32'h000000FF. LH at 0x16 -> 32'h00001234. Each resp_valid arrives exactly 2 cycles after accept.
- SB wdata 32'hAA at addr 0x15 on word 32'h11223344 -> exactly one SW cycle with mem_wdata 32'h11AA3344, at accept+2. A later LW at 0x14 returns 32'h11AA3344.
- SW wdata 32'hDEADBEEF at addr 0x20 -> mem_op = SW only at accept+1, mem_addr 0x20, resp_valid at accept+2.
- LW at addr 0x22 -> exc_valid with cause 1 and exc_addr 0x22. SB at addr 0x1000 (word index 1024) -> exc_valid with cause 2. In both cases mem_op stays OP_NOP throughout.
- Back-to-back req_valid with an SH at 0x42 followed by an LW: the second request is accepted only when req_ready rises. No mem_op glitch occurs between the two accesses.
- Reset during RMW_READ of an SB -> no SW issued, memory unchanged, req_ready = 1 after reset. Reset during WRITE -> memory updated, no resp_valid.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS load/store path: opcodes, fault causes
// and the load/store unit state encoding.
package mips_mem_pkg;

    // MIPS memory opcodes as seen on the pipeline request and memory buses
    localparam logic [5:0] OP_NOP = 6'h00;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Fault cause encodings reported on exc_cause
    localparam logic [1:0] EXC_NONE       = 2'd0;
    localparam logic [1:0] EXC_MISALIGNED = 2'd1;
    localparam logic [1:0] EXC_RANGE      = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_READ,
        ST_WRITE,
        ST_RESP,
        ST_FAULT
    } state_t;

    // True for any of the eight opcodes this unit services
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_SB) ||
               (op == OP_SH) || (op == OP_SW);
    endfunction

    // True for the five load opcodes
    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational big-endian byte/halfword lane handling: extracts and extends
// load results from a memory word, and merges sub-word store data into the
// previously read word.
module mem_lane_unit
    import mips_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [5:0]  op,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane; offset 0 is the most significant byte
    always_comb begin
        byte_sel = word[31:24];
        case (offset)
            2'd0: byte_sel = word[31:24];
            2'd1: byte_sel = word[23:16];
            2'd2: byte_sel = word[15:8];
            2'd3: byte_sel = word[7:0];
            default: byte_sel = word[31:24];
        endcase
        half_sel = offset[1] ? word[15:0] : word[31:16];
    end

    // Sign- or zero-extend the selected lane; full-word loads pass straight through
    always_comb begin
        load_data = word;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h000000, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0000, half_sel};
            default: load_data = word;
        endcase
    end

    // Replace only the target lane(s) of the old word with the store data
    always_comb begin
        merged_word = word;
        if (op == OP_SB) begin
            case (offset)
                2'd0: merged_word[31:24] = store_data[7:0];
                2'd1: merged_word[23:16] = store_data[7:0];
                2'd2: merged_word[15:8]  = store_data[7:0];
                2'd3: merged_word[7:0]   = store_data[7:0];
                default: merged_word = word;
            endcase
        end else if (op == OP_SH) begin
            if (offset[1]) begin
                merged_word[15:0] = store_data;
            end else begin
                merged_word[31:16] = store_data;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of the word-only data memory. Accepts one request
// at a time, turns sub-word accesses into LW or read-modify-write SW
// sequences and reports misaligned or out-of-range addresses as faults.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [31:0] exc_addr,
    output logic [5:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    state_t      state;
    logic [5:0]  op_q;
    logic [1:0]  offset_q;
    logic [15:0] wdata_q;

    logic        req_known;
    logic        req_load;
    logic        misaligned;
    logic        out_of_range;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign req_ready = (state == ST_IDLE);

    // Classify the incoming request; misalignment outranks the range check
    always_comb begin
        req_known    = is_mem_op(req_op);
        req_load     = is_load_op(req_op);
        misaligned   = 1'b0;
        if ((req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH)) begin
            misaligned = req_addr[0];
        end else if ((req_op == OP_LW) || (req_op == OP_SW)) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
        out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
    end

    mem_lane_unit u_lane (
        .word        (mem_rdata),
        .offset      (offset_q),
        .op          (op_q),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    // Access sequencer; every memory and response output is registered here
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            op_q       <= OP_NOP;
            offset_q   <= 2'b00;
            wdata_q    <= 16'h0000;
            mem_op     <= OP_NOP;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            exc_valid  <= 1'b0;
            exc_cause  <= EXC_NONE;
            exc_addr   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_known) begin
                        op_q     <= req_op;
                        offset_q <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        if (misaligned) begin
                            state     <= ST_FAULT;
                            exc_valid <= 1'b1;
                            exc_cause <= EXC_MISALIGNED;
                            exc_addr  <= req_addr;
                        end else if (out_of_range) begin
                            state     <= ST_FAULT;
                            exc_valid <= 1'b1;
                            exc_cause <= EXC_RANGE;
                            exc_addr  <= req_addr;
                        end else if (req_load) begin
                            state    <= ST_LOAD;
                            mem_op   <= OP_LW;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end else if (req_op == OP_SW) begin
                            state     <= ST_WRITE;
                            mem_op    <= OP_SW;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                        end else begin
                            state    <= ST_RMW_READ;
                            mem_addr <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_LOAD: begin
                    mem_op     <= OP_NOP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                    state      <= ST_RESP;
                end
                ST_RMW_READ: begin
                    mem_op    <= OP_SW;
                    mem_wdata <= merged_word;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_op     <= OP_NOP;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_FAULT: begin
                    exc_valid <= 1'b0;
                    exc_cause <= EXC_NONE;
                    state     <= ST_IDLE;
                end
                default: begin
                    mem_op <= OP_NOP;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    logic        clock;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic [5:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [1024];
    logic        pl_en;
    logic [9:0]  pl_idx;
    logic [31:0] pl_data;
    int          sw_count;

    int ntests;
    int nfail;

    mem_access_unit #(.MEM_WORDS(1024)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr),
        .mem_op     (mem_op),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Word memory: combinational read, write when SW is presented at a clock edge
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clock) begin
        if (mem_op == OP_SW) begin
            mem[mem_addr[11:2]] <= mem_wdata;
            sw_count <= sw_count + 1;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clock);
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = data;
        @(posedge clock);
        #1;
        pl_en = 1'b0;
    endtask

    // Waits (bounded) for req_ready, presents one request for a single edge
    task automatic send_req(input logic [5:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata);
        int waited;
        waited = 0;
        @(negedge clock);
        while (!req_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            ntests++;
            nfail++;
            $display("[TB] FAIL send_req_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_op    = OP_NOP;
    endtask

    // Issues a load and waits a bounded number of cycles for its response
    task automatic run_load(input logic [5:0] op, input logic [31:0] addr,
                            output logic [31:0] data, output bit got);
        got  = 1'b0;
        data = 32'h0;
        send_req(op, addr, 32'h0);
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clock);
            if (resp_valid) begin
                got  = 1'b1;
                data = resp_rdata;
            end
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b0;
        req_op    = OP_NOP;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        ntests++; if (req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
        ntests++; if (mem_op !== OP_NOP) begin nfail++; $display("[TB] FAIL reset_mem_op: got %h expected %h", mem_op, OP_NOP); end
        ntests++; if (mem_addr !== 32'h0) begin nfail++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        ntests++; if (mem_wdata !== 32'h0) begin nfail++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        ntests++; if (resp_rdata !== 32'h0) begin nfail++; $display("[TB] FAIL reset_resp_rdata: got %h expected 0", resp_rdata); end
        ntests++; if (exc_valid !== 1'b0) begin nfail++; $display("[TB] FAIL reset_exc_valid: got %b expected 0", exc_valid); end
        ntests++; if (exc_cause !== 2'd0) begin nfail++; $display("[TB] FAIL reset_exc_cause: got %0d expected 0", exc_cause); end
        ntests++; if (exc_addr !== 32'h0) begin nfail++; $display("[TB] FAIL reset_exc_addr: got %h expected 0", exc_addr); end
        reset_n = 1'b1;
    endtask

    task automatic test_loads();
        logic [5:0]  ops  [6];
        logic [31:0] addrs[6];
        logic [31:0] exps [6];
        ops   = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LH, OP_LW};
        addrs = '{32'h14, 32'h15, 32'h16, 32'h14, 32'h14, 32'h14};
        exps  = '{32'hFFFFFF80, 32'h000000FF, 32'h00001234,
                  32'h000080FF, 32'hFFFF80FF, 32'h80FF1234};
        preload(10'd5, 32'h80FF1234);
        for (int i = 0; i < 6; i++) begin
            send_req(ops[i], addrs[i], 32'h0);
            @(negedge clock);
            ntests++; if (mem_op !== OP_LW) begin nfail++; $display("[TB] FAIL load_mem_op[%0d]: got %h expected %h", i, mem_op, OP_LW); end
            ntests++; if (mem_addr !== 32'h14) begin nfail++; $display("[TB] FAIL load_mem_addr[%0d]: got %h expected 14", i, mem_addr); end
            ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL load_early_resp[%0d]: got %b expected 0", i, resp_valid); end
            @(negedge clock);
            ntests++; if (resp_valid !== 1'b1) begin nfail++; $display("[TB] FAIL load_resp_valid[%0d]: got %b expected 1", i, resp_valid); end
            ntests++; if (resp_rdata !== exps[i]) begin nfail++; $display("[TB] FAIL load_rdata[%0d]: got %h expected %h", i, resp_rdata, exps[i]); end
            ntests++; if (mem_op !== OP_NOP) begin nfail++; $display("[TB] FAIL load_mem_op_idle[%0d]: got %h expected 0", i, mem_op); end
            @(negedge clock);
            ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL load_resp_pulse[%0d]: got %b expected 0", i, resp_valid); end
            ntests++; if (req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL load_ready_back[%0d]: got %b expected 1", i, req_ready); end
        end
        // Highest legal word index is serviced normally
        preload(10'd1023, 32'hCAFEF00D);
        begin
            logic [31:0] d;
            bit          got;
            run_load(OP_LW, 32'hFFC, d, got);
            ntests++; if (!got || d !== 32'hCAFEF00D) begin nfail++; $display("[TB] FAIL load_last_word: got %h (resp %b) expected cafef00d", d, got); end
        end
    endtask

    task automatic test_sub_stores();
        int          sw_before;
        logic [31:0] d;
        bit          got;
        preload(10'd5, 32'h11223344);
        sw_before = sw_count;
        send_req(OP_SB, 32'h15, 32'h000000AA);
        @(negedge clock);
        ntests++; if (mem_op !== OP_NOP) begin nfail++; $display("[TB] FAIL sb_read_mem_op: got %h expected 0", mem_op); end
        ntests++; if (mem_addr !== 32'h14) begin nfail++; $display("[TB] FAIL sb_mem_addr: got %h expected 14", mem_addr); end
        @(negedge clock);
        ntests++; if (mem_op !== OP_SW) begin nfail++; $display("[TB] FAIL sb_write_mem_op: got %h expected 2b", mem_op); end
        ntests++; if (mem_wdata !== 32'h11AA3344) begin nfail++; $display("[TB] FAIL sb_mem_wdata: got %h expected 11aa3344", mem_wdata); end
        ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL sb_early_resp: got %b expected 0", resp_valid); end
        @(negedge clock);
        ntests++; if (mem_op !== OP_NOP) begin nfail++; $display("[TB] FAIL sb_after_mem_op: got %h expected 0", mem_op); end
        ntests++; if (resp_valid !== 1'b1) begin nfail++; $display("[TB] FAIL sb_resp_valid: got %b expected 1", resp_valid); end
        ntests++; if (resp_rdata !== 32'h0) begin nfail++; $display("[TB] FAIL sb_resp_rdata: got %h expected 0", resp_rdata); end
        ntests++; if (sw_count - sw_before !== 1) begin nfail++; $display("[TB] FAIL sb_sw_cycles: got %0d expected 1", sw_count - sw_before); end
        run_load(OP_LW, 32'h14, d, got);
        ntests++; if (!got || d !== 32'h11AA3344) begin nfail++; $display("[TB] FAIL sb_readback: got %h (resp %b) expected 11aa3344", d, got); end
        send_req(OP_SH, 32'h16, 32'hFFFF5566);
        repeat (3) @(negedge clock);
        run_load(OP_LW, 32'h14, d, got);
        ntests++; if (!got || d !== 32'h11AA5566) begin nfail++; $display("[TB] FAIL sh_readback: got %h (resp %b) expected 11aa5566", d, got); end
    endtask

    task automatic test_store_word();
        logic [31:0] d;
        bit          got;
        send_req(OP_SW, 32'h20, 32'hDEADBEEF);
        @(negedge clock);
        ntests++; if (mem_op !== OP_SW) begin nfail++; $display("[TB] FAIL sw_mem_op: got %h expected 2b", mem_op); end
        ntests++; if (mem_addr !== 32'h20) begin nfail++; $display("[TB] FAIL sw_mem_addr: got %h expected 20", mem_addr); end
        ntests++; if (mem_wdata !== 32'hDEADBEEF) begin nfail++; $display("[TB] FAIL sw_mem_wdata: got %h expected deadbeef", mem_wdata); end
        @(negedge clock);
        ntests++; if (mem_op !== OP_NOP) begin nfail++; $display("[TB] FAIL sw_after_mem_op: got %h expected 0", mem_op); end
        ntests++; if (resp_valid !== 1'b1) begin nfail++; $display("[TB] FAIL sw_resp_valid: got %b expected 1", resp_valid); end
        run_load(OP_LW, 32'h20, d, got);
        ntests++; if (!got || d !== 32'hDEADBEEF) begin nfail++; $display("[TB] FAIL sw_readback: got %h (resp %b) expected deadbeef", d, got); end
    endtask

    task automatic test_faults();
        logic [5:0]  ops  [3];
        logic [31:0] addrs[3];
        logic [1:0]  causes[3];
        int          sw_before;
        ops    = '{OP_LW, OP_SB, OP_LH};
        addrs  = '{32'h22, 32'h1000, 32'h1001};
        causes = '{2'd1, 2'd2, 2'd1};
        for (int i = 0; i < 3; i++) begin
            sw_before = sw_count;
            send_req(ops[i], addrs[i], 32'h55);
            @(negedge clock);
            ntests++; if (exc_valid !== 1'b1) begin nfail++; $display("[TB] FAIL fault_exc_valid[%0d]: got %b expected 1", i, exc_valid); end
            ntests++; if (exc_cause !== causes[i]) begin nfail++; $display("[TB] FAIL fault_cause[%0d]: got %0d expected %0d", i, exc_cause, causes[i]); end
            ntests++; if (exc_addr !== addrs[i]) begin nfail++; $display("[TB] FAIL fault_addr[%0d]: got %h expected %h", i, exc_addr, addrs[i]); end
            ntests++; if (mem_op !== OP_NOP) begin nfail++; $display("[TB] FAIL fault_mem_op[%0d]: got %h expected 0", i, mem_op); end
            ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("[TB] FAIL fault_resp[%0d]: got %b expected 0", i, resp_valid); end
            @(negedge clock);
            ntests++; if (exc_valid !== 1'b0) begin nfail++; $display("[TB] FAIL fault_pulse[%0d]: got %b expected 0", i, exc_valid); end
            ntests++; if (req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL fault_ready[%0d]: got %b expected 1", i, req_ready); end
            ntests++; if (sw_count !== sw_before) begin nfail++; $display("[TB] FAIL fault_no_write[%0d]: got %0d writes expected 0", i, sw_count - sw_before); end
        end
    endtask

    task automatic test_unknown_op();
        int seen;
        seen = 0;
        send_req(6'h0F, 32'h14, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (resp_valid || exc_valid || !req_ready || mem_op !== OP_NOP) seen++;
        end
        ntests++; if (seen !== 0) begin nfail++; $display("[TB] FAIL unknown_op_ignored: got %0d busy cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_op   [6];
        logic       exp_ready[6];
        logic       exp_resp [6];
        exp_op    = '{OP_NOP, OP_SW, OP_NOP, OP_NOP, OP_LW, OP_NOP};
        exp_ready = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_resp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        preload(10'd16, 32'h01020304);
        @(negedge clock);
        req_valid = 1'b1;
        req_op    = OP_SH;
        req_addr  = 32'h42;
        req_wdata = 32'h0000BEEF;
        @(posedge clock);
        #1;
        req_op    = OP_LW;
        req_addr  = 32'h40;
        req_wdata = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            ntests++; if (mem_op !== exp_op[c]) begin nfail++; $display("[TB] FAIL b2b_mem_op[%0d]: got %h expected %h", c + 1, mem_op, exp_op[c]); end
            ntests++; if (req_ready !== exp_ready[c]) begin nfail++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected %b", c + 1, req_ready, exp_ready[c]); end
            ntests++; if (resp_valid !== exp_resp[c]) begin nfail++; $display("[TB] FAIL b2b_resp[%0d]: got %b expected %b", c + 1, resp_valid, exp_resp[c]); end
            if (c == 1) begin
                ntests++; if (mem_wdata !== 32'h0102BEEF) begin nfail++; $display("[TB] FAIL b2b_sh_wdata: got %h expected 0102beef", mem_wdata); end
            end
            if (c == 5) begin
                ntests++; if (resp_rdata !== 32'h0102BEEF) begin nfail++; $display("[TB] FAIL b2b_lw_rdata: got %h expected 0102beef", resp_rdata); end
            end
            if (c == 3) begin
                @(posedge clock);
                #1;
                req_valid = 1'b0;
                req_op    = OP_NOP;
            end
        end
    endtask

    task automatic test_reset_mid();
        int          sw_before;
        int          resp_seen;
        logic [31:0] d;
        bit          got;
        preload(10'd6, 32'h55667788);
        // Reset while the old word is being read: access must vanish
        sw_before = sw_count;
        send_req(OP_SB, 32'h19, 32'h11);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        resp_seen = 0;
        @(negedge clock);
        ntests++; if (req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL rst_read_ready: got %b expected 1", req_ready); end
        for (int c = 0; c < 3; c++) begin
            if (resp_valid || mem_op !== OP_NOP) resp_seen++;
            @(negedge clock);
        end
        ntests++; if (resp_seen !== 0) begin nfail++; $display("[TB] FAIL rst_read_quiet: got %0d active cycles expected 0", resp_seen); end
        ntests++; if (sw_count !== sw_before) begin nfail++; $display("[TB] FAIL rst_read_no_write: got %0d writes expected 0", sw_count - sw_before); end
        run_load(OP_LW, 32'h18, d, got);
        ntests++; if (!got || d !== 32'h55667788) begin nfail++; $display("[TB] FAIL rst_read_mem: got %h (resp %b) expected 55667788", d, got); end
        // Reset during the write cycle: write lands, no response
        send_req(OP_SB, 32'h19, 32'h11);
        @(negedge clock);
        @(negedge clock);
        ntests++; if (mem_op !== OP_SW) begin nfail++; $display("[TB] FAIL rst_write_phase: got %h expected 2b", mem_op); end
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        resp_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (resp_valid) resp_seen++;
        end
        ntests++; if (resp_seen !== 0) begin nfail++; $display("[TB] FAIL rst_write_no_resp: got %0d pulses expected 0", resp_seen); end
        ntests++; if (req_ready !== 1'b1) begin nfail++; $display("[TB] FAIL rst_write_ready: got %b expected 1", req_ready); end
        run_load(OP_LW, 32'h18, d, got);
        ntests++; if (!got || d !== 32'h55117788) begin nfail++; $display("[TB] FAIL rst_write_mem: got %h (resp %b) expected 55117788", d, got); end
    endtask

    initial begin
        ntests   = 0;
        nfail    = 0;
        sw_count = 0;
        pl_en    = 1'b0;
        pl_idx   = 10'd0;
        pl_data  = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_loads();
        test_sub_stores();
        test_store_word();
        test_faults();
        test_unknown_op();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
